// File: rtl/system_bus_ctrl_if.sv
// rtl/system_bus_ctrl_if.sv - CPU, device and interrupt signal bundle for system_bus_ctrl
interface system_bus_ctrl_if #(
    parameter int NUM_DEV = 4,
    parameter int NUM_IRQ = 8
) ();
    logic [31:0]           cpu_addr;
    logic                  cpu_read_en;
    logic                  cpu_write_en;
    logic [2:0]            cpu_read_type;
    logic [31:0]           cpu_write_data;
    logic [31:0]           cpu_read_data;
    logic                  cpu_ready;
    logic                  cpu_bus_error;
    logic                  cpu_interrupt;
    logic [4:0]            cpu_interrupt_id;
    logic                  cpu_interrupt_ack;
    logic [31:0]           dev_addr;
    logic [2:0]            dev_read_type;
    logic [31:0]           dev_write_data;
    logic [NUM_DEV-1:0]    dev_sel;
    logic [NUM_DEV-1:0]    dev_write_en;
    logic [32*NUM_DEV-1:0] dev_read_data;
    logic [NUM_DEV-1:0]    dev_ready;
    logic [NUM_IRQ-1:0]    irq_in;

    // The controller answers CPU requests, so it takes the slave view
    modport slave (
        input  cpu_addr, cpu_read_en, cpu_write_en, cpu_read_type, cpu_write_data,
        input  cpu_interrupt_ack, dev_read_data, dev_ready, irq_in,
        output cpu_read_data, cpu_ready, cpu_bus_error, cpu_interrupt, cpu_interrupt_id,
        output dev_addr, dev_read_type, dev_write_data, dev_sel, dev_write_en
    );

    modport master (
        output cpu_addr, cpu_read_en, cpu_write_en, cpu_read_type, cpu_write_data,
        output cpu_interrupt_ack, dev_read_data, dev_ready, irq_in,
        input  cpu_read_data, cpu_ready, cpu_bus_error, cpu_interrupt, cpu_interrupt_id,
        input  dev_addr, dev_read_type, dev_write_data, dev_sel, dev_write_en
    );
endinterface

// File: rtl/system_bus_ctrl.sv
// rtl/system_bus_ctrl.sv - address-decoded bus controller with wait states, timeout and interrupt aggregator
module system_bus_ctrl #(
    parameter int NUM_DEV  = 4,
    parameter int SEL_BITS = 2,
    parameter int NUM_IRQ  = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    system_bus_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [SEL_BITS:0] NUM_DEV_W = (SEL_BITS + 1)'(NUM_DEV);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic                wr_q;
    logic [CW-1:0]       cnt;
    logic [SEL_BITS-1:0] req_idx;
    logic                req_ok;
    logic [NUM_DEV-1:0]  req_sel;
    logic [31:0]         sel_data;
    logic                sel_ready;

    assign req_idx   = bus.cpu_addr[31 -: SEL_BITS];
    assign req_ok    = ({1'b0, req_idx} < NUM_DEV_W) && (bus.cpu_read_en ^ bus.cpu_write_en);
    assign req_sel   = NUM_DEV'(1) << req_idx;
    // Only the selected device may complete the access; others' ready is masked out
    assign sel_ready = |(bus.dev_ready & bus.dev_sel);

    always_comb begin
        sel_data = 32'h0;
        for (int i = 0; i < NUM_DEV; i++) begin
            sel_data = sel_data | (bus.dev_read_data[32*i +: 32] & {32{bus.dev_sel[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            wr_q               <= 1'b0;
            cnt                <= '0;
            bus.dev_addr       <= 32'h0;
            bus.dev_read_type  <= 3'h0;
            bus.dev_write_data <= 32'h0;
            bus.dev_sel        <= '0;
            bus.dev_write_en   <= '0;
            bus.cpu_read_data  <= 32'h0;
            bus.cpu_ready      <= 1'b0;
            bus.cpu_bus_error  <= 1'b0;
        end else begin
            bus.cpu_ready     <= 1'b0;
            bus.cpu_bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_read_en || bus.cpu_write_en) begin
                        bus.dev_addr       <= bus.cpu_addr;
                        bus.dev_write_data <= bus.cpu_write_data;
                        bus.dev_read_type  <= bus.cpu_read_type;
                        wr_q               <= bus.cpu_write_en;
                        if (req_ok) begin
                            state            <= ACCESS;
                            cnt              <= '0;
                            bus.dev_sel      <= req_sel;
                            bus.dev_write_en <= bus.cpu_write_en ? req_sel : '0;
                        end else begin
                            state             <= RESP;
                            bus.cpu_ready     <= 1'b1;
                            bus.cpu_bus_error <= 1'b1;
                            bus.cpu_read_data <= 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        state             <= RESP;
                        bus.cpu_ready     <= 1'b1;
                        bus.cpu_read_data <= wr_q ? 32'h0 : sel_data;
                        bus.dev_sel       <= '0;
                        bus.dev_write_en  <= '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state             <= RESP;
                        bus.cpu_ready     <= 1'b1;
                        bus.cpu_bus_error <= 1'b1;
                        bus.cpu_read_data <= 32'h0;
                        bus.dev_sel       <= '0;
                        bus.dev_write_en  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [4:0]         irq_id;

    always_comb begin
        irq_id = 5'd0;
        for (int j = NUM_IRQ - 1; j >= 0; j--) begin
            if (pending[j]) irq_id = 5'(j);
        end
    end

    assign ack_mask             = bus.cpu_interrupt_ack ? (NUM_IRQ'(1) << irq_id) : '0;
    assign bus.cpu_interrupt    = |pending;
    assign bus.cpu_interrupt_id = irq_id;

    // A fresh edge is OR-ed in after the clear so it survives a coincident ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= bus.irq_in;
            pending  <= (pending & ~ack_mask) | (bus.irq_in & ~irq_prev);
        end
    end
endmodule

// File: tb/tb_system_bus_ctrl.sv
// tb/tb_system_bus_ctrl.sv - scoreboard bench for system_bus_ctrl (3 devices, timeout 4)
module tb_system_bus_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    system_bus_ctrl_if #(.NUM_DEV(3), .NUM_IRQ(8)) bus ();

    system_bus_ctrl #(.NUM_DEV(3), .SEL_BITS(2), .NUM_IRQ(8), .TIMEOUT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          run;
    } resp_t;

    resp_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          waits[3] = '{255, 0, 255};
    logic [2:0]  tie = 3'b010;
    logic [2:0]  exp_sel = 3'b000;
    logic [2:0]  exp_we = 3'b000;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [2:0]  exp_rtype = 3'h0;

    assign bus.dev_read_data = {32'h55AA_1234, 32'hDEAD_BEEF, 32'h0000_AAAA};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bus.dev_ready[i] = tie[i] | (bus.dev_sel[i] && (acc_cnt >= waits[i]));
        end
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        acc_cnt <= (bus.dev_sel == 3'b000) ? 0 : acc_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed access against the scoreboard
    initial begin
        int    run;
        resp_t r;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else begin
                if (bus.dev_sel != 3'b000) begin
                    run++;
                    check("dev_sel", 32'(bus.dev_sel), 32'(exp_sel));
                    check("dev_write_en", 32'(bus.dev_write_en), 32'(exp_we));
                    check("dev_addr", bus.dev_addr, exp_addr);
                    check("dev_read_type", 32'(bus.dev_read_type), 32'(exp_rtype));
                    if (exp_we != 3'b000) check("dev_write_data", bus.dev_write_data, exp_wdata);
                end
                if (bus.cpu_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got cpu_ready=1 at cycle %0d expected none", cyc);
                    end else begin
                        r = sb.pop_front();
                        check("read_data", bus.cpu_read_data, r.data);
                        check("bus_error", 32'(bus.cpu_bus_error), 32'(r.err));
                        check("ready_cycle", 32'(cyc), 32'(r.cyc));
                        check("sel_cycles", 32'(run), 32'(r.run));
                    end
                    run = 0;
                end
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] edata, input logic eerr,
                        input int lat, input logic [2:0] esel, input int erun, input bit perturb);
        bit done;
        @(negedge clk);
        exp_addr  = addr;
        exp_sel   = esel;
        exp_we    = (wr && !rd) ? esel : 3'b000;
        exp_wdata = wdata;
        exp_rtype = 3'b010;
        bus.cpu_addr       = addr;
        bus.cpu_read_en    = rd;
        bus.cpu_write_en   = wr;
        bus.cpu_write_data = wdata;
        bus.cpu_read_type  = 3'b010;
        sb.push_back('{edata, eerr, cyc + 1 + lat, erun});
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (perturb && n == 0) begin
                bus.cpu_addr       = 32'h4000_0000;
                bus.cpu_write_data = 32'hFFFF_FFFF;
                bus.cpu_read_type  = 3'h7;
            end
            if (bus.cpu_ready) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no cpu_ready for 0x%08h expected one within 40 cycles", addr);
            sb.delete();
        end
        bus.cpu_read_en  = 1'b0;
        bus.cpu_write_en = 1'b0;
    endtask

    task automatic irq_chk(input string name, input logic eint, input logic [4:0] eid);
        check({name, "_int"}, 32'(bus.cpu_interrupt), 32'(eint));
        check({name, "_id"}, 32'(bus.cpu_interrupt_id), 32'(eid));
    endtask

    task automatic ack_pulse();
        bus.cpu_interrupt_ack = 1'b1;
        @(negedge clk);
        bus.cpu_interrupt_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        check({name, "_dev_sel"}, 32'(bus.dev_sel), 32'h0);
        check({name, "_dev_we"}, 32'(bus.dev_write_en), 32'h0);
        check({name, "_dev_addr"}, bus.dev_addr, 32'h0);
        check({name, "_rdata"}, bus.cpu_read_data, 32'h0);
        check({name, "_ready"}, 32'(bus.cpu_ready), 32'h0);
        check({name, "_irq"}, 32'(bus.cpu_interrupt), 32'h0);
        check({name, "_irq_id"}, 32'(bus.cpu_interrupt_id), 32'h0);
    endtask

    initial begin
        bus.cpu_addr          = 32'h0;
        bus.cpu_read_en       = 1'b0;
        bus.cpu_write_en      = 1'b0;
        bus.cpu_read_type     = 3'h0;
        bus.cpu_write_data    = 32'h0;
        bus.cpu_interrupt_ack = 1'b0;
        bus.irq_in            = 8'h00;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        xfer(32'h4000_0010, 1, 0, 32'h0,         32'hDEAD_BEEF, 0, 1, 3'b010, 1, 0);
        waits[2] = 3;
        xfer(32'h8000_0004, 0, 1, 32'h1234_5678, 32'h0,         0, 4, 3'b100, 4, 1);
        xfer(32'hC000_0000, 1, 0, 32'h0,         32'h0,         1, 0, 3'b000, 0, 0);
        xfer(32'h0000_0000, 1, 1, 32'h0,         32'h0,         1, 0, 3'b000, 0, 0);
        xfer(32'h0000_0020, 1, 0, 32'h0,         32'h0,         1, 4, 3'b001, 4, 0);
        waits[0] = 0;
        xfer(32'h0000_0100, 0, 1, 32'hCAFE_F00D, 32'h0,         0, 1, 3'b001, 1, 0);
        waits[2] = 2;
        xfer(32'h8000_0000, 1, 0, 32'h0,         32'h55AA_1234, 0, 3, 3'b100, 3, 0);
        repeat (2) @(negedge clk);
        check("rdata_hold", bus.cpu_read_data, 32'h55AA_1234);

        bus.irq_in = 8'h24;
        @(negedge clk); irq_chk("irq_both", 1, 5'd2);
        ack_pulse();    irq_chk("irq_ack1", 1, 5'd5);
        ack_pulse();    irq_chk("irq_ack2", 0, 5'd0);
        repeat (2) @(negedge clk);
        irq_chk("irq_held", 0, 5'd0);
        bus.irq_in = 8'h20;
        @(negedge clk); bus.irq_in = 8'h24;
        @(negedge clk); irq_chk("irq_repend", 1, 5'd2);
        bus.irq_in = 8'h20;
        @(negedge clk); bus.irq_in = 8'h24;
        ack_pulse();    irq_chk("irq_set_wins", 1, 5'd2);
        ack_pulse();    irq_chk("irq_cleared", 0, 5'd0);
        ack_pulse();    irq_chk("irq_empty_ack", 0, 5'd0);
        bus.irq_in = 8'h25;
        @(negedge clk); irq_chk("irq_line0", 1, 5'd0);
        ack_pulse();    irq_chk("irq_line0_ack", 0, 5'd0);
        bus.irq_in = 8'h00;
        @(negedge clk);

        bus.irq_in = 8'h80;
        @(negedge clk); irq_chk("irq_line7", 1, 5'd7);
        waits[2]  = 255;
        exp_sel   = 3'b100;
        exp_we    = 3'b000;
        exp_addr  = 32'h8000_0000;
        exp_rtype = 3'b010;
        bus.cpu_addr      = 32'h8000_0000;
        bus.cpu_read_type = 3'b010;
        bus.cpu_read_en   = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_sel", 32'(bus.dev_sel), 32'h4);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        bus.cpu_read_en = 1'b0;
        bus.irq_in      = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        xfer(32'h4000_0000, 1, 0, 32'h0, 32'hDEAD_BEEF, 0, 1, 3'b010, 1, 0);
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected completion within 100000 time units");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/system_bus_ctrl.md
Name: system_bus_ctrl

Overview:
Parametrised, clocked successor to the two-target system bus. Sits between the CPU load/store port and NUM_DEV address-decoded peripherals (memory, IO, timers, and so on).
- Adds a request/ready handshake with device wait states, a timeout, and bus-error reporting for unmapped or malformed accesses.
- Adds an interrupt aggregator: edge-latched pending bits, fixed-priority ID encoding, and CPU acknowledge.

Parameters:
NUM_DEV, 4, number of target devices (1..2^SEL_BITS)
SEL_BITS, 2, number of top address bits used as device index (cpu_addr[31:32-SEL_BITS])
NUM_IRQ, 8, number of interrupt lines (1..32)
TIMEOUT, 255, ACCESS cycles before bus error (1..65535); counter width $clog2(TIMEOUT+1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cpu_addr  in  32  access address
cpu_read_en  in  1  read request, held until cpu_ready
cpu_write_en  in  1  write request, held until cpu_ready
cpu_read_type  in  3  load size/sign code, forwarded unchanged
cpu_write_data  in  32  store data
cpu_read_data  out  32  read response data, valid while cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_bus_error  out  1  qualifies cpu_ready: access failed
cpu_interrupt  out  1  any interrupt pending
cpu_interrupt_id  out  5  lowest-index pending line
cpu_interrupt_ack  in  1  one-cycle pulse, clears pending[cpu_interrupt_id]
dev_addr  out  32  latched address, shared by all devices
dev_read_type  out  3  latched read type, shared
dev_write_data  out  32  latched store data, shared
dev_sel  out  NUM_DEV  one-hot select
dev_write_en  out  NUM_DEV  one-hot write strobe
dev_read_data  in  32*NUM_DEV  device i occupies bits [32i+31:32i]
dev_ready  in  NUM_DEV  device i completes the access
irq_in  in  NUM_IRQ  level interrupt requests, synchronous to clk

Behaviour:
- Reset (async assert, sync release). FSM=IDLE. All outputs 0, including dev_addr, dev_write_data, cpu_read_data and cpu_interrupt_id. Pending bits=0, irq_prev=0, timeout counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - A request is cpu_read_en|cpu_write_en sampled at an edge. On a request, latch addr, write_data, read_type and op, and compute idx=cpu_addr[31:32-SEL_BITS].
  - idx<NUM_DEV and exactly one enable high: go to ACCESS, clear the counter.
  - idx>=NUM_DEV, or read_en and write_en both high: go to RESP with error=1. No device is ever selected.
- ACCESS:
  - dev_sel[idx]=1. For a write, dev_write_en[idx]=1 for the whole state. All other bits 0.
  - dev_ready[idx]=1 at an edge: capture dev_read_data[idx] (reads; writes capture 0), error=0, go to RESP.
  - Otherwise increment the counter. At counter==TIMEOUT-1 without ready: error=1, read data=0, go to RESP.
  - dev_ready of non-selected devices is ignored.
- RESP:
  - cpu_ready=1 for exactly one cycle; cpu_bus_error=error; cpu_read_data=captured data. Then go to IDLE unconditionally.
  - cpu_read_data holds its value until the next RESP.
- Latency:
  - Request sampled at edge k, device ready during cycle k+1: cpu_ready in cycle k+2.
  - Each wait cycle adds 1.
  - Error for unmapped or both-enables: cpu_ready in cycle k+1.
- Back-to-back: the CPU deasserts or changes its request at the edge ending RESP. A request is sampled only in IDLE, so the minimum spacing is 3 cycles.
- Changes to cpu_* inputs after latching are ignored until IDLE.
- Interrupts:
  - irq_prev <= irq_in every cycle.
  - pending[j] set at an edge where irq_in[j]&~irq_prev[j].
  - pending[j] cleared at an edge where cpu_interrupt_ack and j==cpu_interrupt_id.
  - If set and clear coincide on the same line, set wins.
  - cpu_interrupt=|pending (combinational from the register).
  - cpu_interrupt_id=lowest j with pending[j], 0 if none.
  - A rising irq_in sampled at edge e gives cpu_interrupt high from cycle e+1.
  - An ack with nothing pending has no effect.
- The interrupt logic runs independently of, and concurrently with, the access FSM.
- rst_n asserted mid-access: the FSM returns to IDLE immediately, dev_sel/dev_write_en drop asynchronously, pending bits are lost, and no cpu_ready is issued.

Test Plan:
- NUM_DEV=4, read 0x4000_0010, dev_ready[1] tied 1, dev_read_data[1]=0xDEADBEEF -> dev_sel=4'b0010 for 1 cycle; cpu_ready 2 cycles after the sampling edge with data 0xDEADBEEF, bus_error=0.
- Write 0x8000_0004, data 0x12345678, dev_ready[2] raised after 3 wait cycles -> dev_write_en=4'b0100 for 4 cycles, dev_write_data=0x12345678; cpu_ready 5 cycles after the sampling edge.
- NUM_DEV=3, read 0xC000_0000 -> no dev_sel; cpu_ready 1 cycle later with bus_error=1. Both enables high to 0x0 -> same error response.
- TIMEOUT=4, read device 0, dev_ready never asserted -> dev_sel[0] high for exactly 4 cycles, then cpu_ready with bus_error=1 and read_data=0.
- irq_in[5] and irq_in[2] rise together -> cpu_interrupt=1, id=2; ack -> id=5; ack -> cpu_interrupt=0. A held level does not re-pend; ack coincident with a new edge on line 2 keeps pending[2]=1.
- rst_n pulsed low during ACCESS with a pending IRQ -> all outputs 0 asynchronously. After release, a new read completes normally.
